id_ex_hazard_reg: RTL and testbench

//  ID/EX pipeline register with load-use hazard detection and stall/flush control. Captures decoded

---
 rtl/id_ex_hazard_reg_pkg.sv | 42 ++++
 rtl/id_ex_hazard_reg_sat_counter.sv | 20 ++
 rtl/id_ex_hazard_reg.sv | 123 ++++++++++++
 tb/tb_id_ex_hazard_reg.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_hazard_reg_pkg.sv
// rtl/id_ex_hazard_reg_pkg.sv - rv32i opcode encodings, hazard FSM states and NOP field values
package id_ex_hazard_reg_pkg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    HOLD   = 2'd2
  } hazard_state_t;

  localparam logic       NOP_VALID        = 1'b0;
  localparam logic       NOP_LOAD_REGFILE = 1'b0;
  localparam logic [6:0] NOP_OPCODE       = 7'b0000000;
  localparam logic [4:0] NOP_RD           = 5'd0;

  function automatic logic uses_rs1(input logic [6:0] op);
    case (op)
      op_jalr, op_br, op_load, op_store, op_imm, op_reg: uses_rs1 = 1'b1;
      default:                                           uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    case (op)
      op_br, op_store, op_reg: uses_rs2 = 1'b1;
      default:                 uses_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_ex_hazard_reg_sat_counter.sv
// rtl/id_ex_hazard_reg_sat_counter.sv - event counter that sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// rtl/id_ex_hazard_reg.sv - ID/EX pipeline register with load-use bubble, stall freeze and flush
module id_ex_hazard_reg
  import id_ex_hazard_reg_pkg::*;
#(
  parameter int CTRL_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [6:0]        id_opcode,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_load_regfile,
  input  logic [3:0]        id_regfilemux_sel,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       fwd_rs1_data,
  input  logic [31:0]       fwd_rs2_data,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [6:0]        ex_opcode,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic              ex_load_regfile,
  output logic [3:0]        ex_regfilemux_sel,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       ex_rs1_out,
  output logic [31:0]       ex_rs2_out,
  output logic              id_hold,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  hold_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output hazard_state_t     state
);

  logic lu;
  logic do_bubble;
  logic do_flush;
  logic capture;
  logic load_nop;

  // x0 is excluded so a load into x0 never stalls its consumer
  assign lu = ex_valid && (ex_opcode == op_load) && (ex_rd != 5'd0) && id_valid &&
              ((uses_rs1(id_opcode) && (id_rs1 == ex_rd)) ||
               (uses_rs2(id_opcode) && (id_rs2 == ex_rd)));

  assign do_flush  = !mem_stall && flush;
  assign do_bubble = !mem_stall && !flush && lu;
  assign capture   = !mem_stall && !flush && !lu && id_valid;
  assign load_nop  = !mem_stall && !capture;
  assign id_hold   = mem_stall || (lu && !flush);

  always_ff @(posedge clk) begin
    if (!rst || load_nop) begin
      ex_valid          <= NOP_VALID;
      ex_pc             <= '0;
      ex_opcode         <= NOP_OPCODE;
      ex_rs1            <= '0;
      ex_rs2            <= '0;
      ex_rd             <= NOP_RD;
      ex_load_regfile   <= NOP_LOAD_REGFILE;
      ex_regfilemux_sel <= '0;
      ex_ctrl           <= '0;
      ex_rs1_out        <= '0;
      ex_rs2_out        <= '0;
    end else if (capture) begin
      ex_valid          <= 1'b1;
      ex_pc             <= id_pc;
      ex_opcode         <= id_opcode;
      ex_rs1            <= id_rs1;
      ex_rs2            <= id_rs2;
      ex_rd             <= id_rd;
      ex_load_regfile   <= id_load_regfile;
      ex_regfilemux_sel <= id_regfilemux_sel;
      ex_ctrl           <= id_ctrl;
      ex_rs1_out        <= fwd_rs1_data;
      ex_rs2_out        <= fwd_rs2_data;
    end
  end

  // State only mirrors which priority branch won; nothing downstream depends on it
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
    end else if (mem_stall) begin
      state <= HOLD;
    end else if (do_bubble) begin
      state <= BUBBLE;
    end else begin
      state <= RUN;
    end
  end

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (do_bubble),
    .clear (1'b0),
    .count (bubble_cnt)
  );

  sat_counter #(.W(CNT_W)) u_hold_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mem_stall),
    .clear (1'b0),
    .count (hold_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (do_flush),
    .clear (1'b0),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// tb/tb_id_ex_hazard_reg.sv - directed and randomized check of id_ex_hazard_reg against a reference model
module tb_id_ex_hazard_reg;
  import id_ex_hazard_reg_pkg::*;

  localparam int CTRL_W = 32;
  localparam int CNT_W  = 4;
  localparam int CMAX   = 15;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] REG   = 7'b0110011;

  logic              clk, rst, mem_stall, flush, id_valid;
  logic [31:0]       id_pc;
  logic [6:0]        id_opcode;
  logic [4:0]        id_rs1, id_rs2, id_rd;
  logic              id_load_regfile;
  logic [3:0]        id_regfilemux_sel;
  logic [CTRL_W-1:0] id_ctrl;
  logic [31:0]       fwd_rs1_data, fwd_rs2_data;
  logic              ex_valid;
  logic [31:0]       ex_pc;
  logic [6:0]        ex_opcode;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic              ex_load_regfile;
  logic [3:0]        ex_regfilemux_sel;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [31:0]       ex_rs1_out, ex_rs2_out;
  logic              id_hold;
  logic [CNT_W-1:0]  bubble_cnt, hold_cnt, flush_cnt;
  logic [1:0]        state;

  id_ex_hazard_reg #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mem_stall(mem_stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_load_regfile(id_load_regfile), .id_regfilemux_sel(id_regfilemux_sel), .id_ctrl(id_ctrl),
    .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_load_regfile(ex_load_regfile), .ex_regfilemux_sel(ex_regfilemux_sel),
    .ex_ctrl(ex_ctrl), .ex_rs1_out(ex_rs1_out), .ex_rs2_out(ex_rs2_out), .id_hold(id_hold),
    .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt), .flush_cnt(flush_cnt), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [6:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic        lr;
    logic [3:0]  mux;
    logic [31:0] ctrl, a, b;
  } ex_m_t;

  ex_m_t m;
  int    m_bub, m_hold, m_flush;
  int    m_state;
  int    total = 0;
  int    bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic reads1(input logic [6:0] op);
    return op inside {7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
  endfunction

  function automatic logic reads2(input logic [6:0] op);
    return op inside {7'b1100011, 7'b0100011, 7'b0110011};
  endfunction

  function automatic logic model_lu();
    return m.v && (m.op == LOAD) && (m.rd != 0) && id_valid &&
           ((reads1(id_opcode) && id_rs1 == m.rd) || (reads2(id_opcode) && id_rs2 == m.rd));
  endfunction

  function automatic int bump(input int c);
    return (c < CMAX) ? c + 1 : c;
  endfunction

  task automatic model_clear();
    m = '{default: '0};
    m_bub = 0; m_hold = 0; m_flush = 0; m_state = 0;
  endtask

  task automatic model_step();
    logic lu;
    lu = model_lu();
    if (!rst) begin
      model_clear();
    end else if (mem_stall) begin
      m_hold = bump(m_hold); m_state = 2;
    end else if (flush) begin
      m = '{default: '0}; m_flush = bump(m_flush); m_state = 0;
    end else if (lu) begin
      m = '{default: '0}; m_bub = bump(m_bub); m_state = 1;
    end else begin
      m_state = 0;
      if (id_valid)
        m = '{v: 1'b1, pc: id_pc, op: id_opcode, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
              lr: id_load_regfile, mux: id_regfilemux_sel, ctrl: id_ctrl,
              a: fwd_rs1_data, b: fwd_rs2_data};
      else
        m = '{default: '0};
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("id_hold", 64'(id_hold), 64'(mem_stall | (model_lu() & ~flush)));
    @(posedge clk);
    model_step();
    #1;
    check("ex_fields", {4'b0, ex_valid, ex_pc, ex_opcode, ex_rs1, ex_rs2, ex_rd, ex_load_regfile, ex_regfilemux_sel},
                       {4'b0, m.v, m.pc, m.op, m.rs1, m.rs2, m.rd, m.lr, m.mux});
    check("ex_ctrl", 64'(ex_ctrl), 64'(m.ctrl));
    check("ex_ops", {ex_rs1_out, ex_rs2_out}, {m.a, m.b});
    check("cnts", {bubble_cnt, hold_cnt, flush_cnt}, {4'(m_bub), 4'(m_hold), 4'(m_flush)});
    check("state", 64'(state), 64'(m_state));
  endtask

  task automatic set_id(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [31:0] a, input logic [31:0] b);
    id_valid = 1'b1; id_opcode = op; id_rd = rd; id_rs1 = r1; id_rs2 = r2;
    fwd_rs1_data = a; fwd_rs2_data = b;
    id_pc = $urandom; id_ctrl = $urandom;
    id_load_regfile = (op != STORE); id_regfilemux_sel = 4'($urandom_range(0, 15));
  endtask

  task automatic do_reset();
    rst = 1'b0; tick(); rst = 1'b1;
  endtask

  logic [6:0] ops [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                           7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011};

  initial begin
    model_clear();
    rst = 1'b0; mem_stall = 1'b0; flush = 1'b0;
    set_id(REG, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7);

    // reset held two cycles with a live instruction in ID
    tick(); tick();
    check("rst_valid", 64'(ex_valid), 64'd0);
    check("rst_opcode", 64'(ex_opcode), 64'd0);
    check("rst_state", 64'(state), 64'(RUN));
    rst = 1'b1;

    // independent add
    set_id(REG, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7);
    tick();
    check("add_rd", 64'(ex_rd), 64'd3);
    check("add_ops", {ex_rs1_out, ex_rs2_out}, {32'd5, 32'd7});

    // load-use bubble then capture
    set_id(LOAD, 5'd5, 5'd1, 5'd0, 32'h100, 32'h0);
    tick();
    set_id(REG, 5'd6, 5'd5, 5'd0, 32'hDEAD, 32'h0);
    tick();
    check("lu_nop", 64'(ex_valid), 64'd0);
    check("lu_bub", 64'(bubble_cnt), 64'd1);
    check("lu_state", 64'(state), 64'(BUBBLE));
    tick();
    check("lu_after", {ex_valid, ex_rs1_out}, {1'b1, 32'hDEAD});

    // flush beats load-use; load to x0 does not stall
    do_reset();
    set_id(LOAD, 5'd5, 5'd1, 5'd0, 32'h0, 32'h0);
    tick();
    set_id(REG, 5'd6, 5'd5, 5'd0, 32'h1, 32'h2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_cnts", {flush_cnt, bubble_cnt}, {4'd1, 4'd0});
    set_id(LOAD, 5'd0, 5'd1, 5'd0, 32'h0, 32'h0);
    tick();
    set_id(REG, 5'd1, 5'd0, 5'd0, 32'h3, 32'h4);
    tick();
    check("x0_nostall", {ex_valid, bubble_cnt}, {1'b1, 4'd0});

    // three-cycle stall, then load-use under stall
    do_reset();
    set_id(REG, 5'd7, 5'd1, 5'd2, 32'h11, 32'h22);
    tick();
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(REG, 5'd8, 5'd3, 5'd4, $urandom, $urandom);
      tick();
    end
    check("hold_cnt3", 64'(hold_cnt), 64'd3);
    check("hold_keep", {ex_rd, ex_rs1_out}, {5'd7, 32'h11});
    mem_stall = 1'b0;
    tick();
    check("hold_rel", 64'(state), 64'(RUN));
    set_id(LOAD, 5'd5, 5'd1, 5'd0, 32'h0, 32'h0);
    tick();
    set_id(REG, 5'd6, 5'd5, 5'd0, 32'h9, 32'h0);
    mem_stall = 1'b1;
    tick();
    check("lu_stall", {hold_cnt, bubble_cnt}, {4'd4, 4'd0});
    mem_stall = 1'b0;
    tick();
    check("lu_release", 64'(bubble_cnt), 64'd1);

    // saturation and store-data hazard
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_id(LOAD, 5'd5, 5'd1, 5'd0, 32'h0, 32'h0);
      tick();
      set_id(REG, 5'd6, 5'd5, 5'd0, 32'h1, 32'h0);
      tick(); tick();
    end
    check("sat_bub", 64'(bubble_cnt), 64'(CMAX));
    set_id(LOAD, 5'd5, 5'd1, 5'd0, 32'h0, 32'h0);
    tick();
    set_id(STORE, 5'd0, 5'd1, 5'd5, 32'h0, 32'h0);
    tick();
    check("sw_stall", 64'(state), 64'(BUBBLE));

    // random traffic with small register range to provoke hazards
    for (int i = 0; i < 800; i++) begin
      set_id(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), $urandom, $urandom);
      id_valid  = ($urandom_range(0, 99) < 85);
      mem_stall = ($urandom_range(0, 99) < 15);
      flush     = ($urandom_range(0, 99) < 10);
      rst       = ($urandom_range(0, 99) >= 2);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
